demux_reg: RTL and testbench
============================

# demux_reg

Registered 1-to-N demultiplexer with valid/ready handshake: steers one input transaction to the output port given by its select field and holds it in a per-port one-entry register until that port accepts it. It is the steering counterpart to the N-to-1 mux and sits wherever a single producer fans out to several consumers, such as dispatch to issue queues or writeback fan-out. Each output stalls independently, so a blocked consumer back-pressures only transactions aimed at it.

## Interface
- WIDTH, 32, payload bits per transaction
- N_OUTS, 4, number of output ports (≥2, need not be a power of 2)
- SEL_WIDTH, $clog2(N_OUTS), localparam, select width

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input transaction present
- in_ready  out  1  input accepted this cycle when high with in_valid
- in_sel  in  SEL_WIDTH  destination port index
- in_data  in  WIDTH  payload
- out_valid  out  N_OUTS  port i holds a transaction
- out_ready  in  N_OUTS  consumer i takes its transaction this cycle
- out_data  out  [N_OUTS][WIDTH]  payload held for port i
- drop_cnt  out  16  out-of-range drop count; present only with DEMUX_REG_STATS_EN

## Operation
- Port i has one register slot (full flag and data). out_valid[i] is the full flag, and out_data[i] is the slot data.
- Decode: one-hot en[i] = (in_sel == i). in_sel ≥ N_OUTS gives all-zero en.
- in_ready = en==0 ? 1 : (~out_valid[in_sel] | out_ready[in_sel]). Pass-through-on-drain is allowed: a full slot being drained this cycle can accept a new transaction in the same cycle.
- Accept = in_valid & in_ready.
- Per port i, each cycle:
  - load_i = accept & en[i]
  - drain_i = out_valid[i] & out_ready[i]
  - next full = load_i | (out_valid[i] & ~drain_i)
  - data register written only on load_i; otherwise held
- Out-of-range select with in_valid: the transaction is accepted and discarded, and no port changes.
- in_ready depends combinationally on in_sel, in_valid-independent signals, and out_ready. It does not depend on in_valid.
- Ports other than in_sel drain independently in the same cycle as a load.
- out_data[i] is don't-care while out_valid[i]=0, but it must equal the last loaded value so the bench can compare deterministically.

## Timing
- Latency: accepted at edge t, visible on out_valid/out_data from edge t onward, i.e. the next cycle. There is no combinational in→out path.
- Throughput: one transaction per cycle to the same port while its consumer holds out_ready=1.
- Reset values: out_valid=0, out_data=0 for all ports, drop_cnt=0. During rst, in_ready still follows the formula with out_valid=0 (i.e. 1), but no load occurs.
- Reset mid-operation: held transactions are discarded. There are no outputs valid the cycle after rst is released.
- Simultaneous load and drain on the same port: the new data replaces the old, and out_valid stays 1.

## Configuration
- DEMUX_REG_STATS_EN defined:
  - adds the drop_cnt port, a 16-bit counter incremented on each accepted out-of-range transaction
  - the counter saturates at 16'hFFFF and is cleared by rst
- Not defined: no drop_cnt port and no counter logic. Functional behaviour is otherwise identical.

## Structure
- Shared package demux_pkg holds:
  - DROP_CNT_WIDTH = 16
  - DROP_CNT_MAX = 16'hFFFF
- One sub-module, sel_decode (SEL_WIDTH→N_OUTS one-hot decoder, all-zero for index ≥ N_OUTS), instanced once.
- Per-port slot logic is a generate loop, not a separate module.

## Test plan
- Reset and single transfer: assert rst for 2 cycles, then in_valid=1, in_sel=2, in_data=0xDEADBEEF, out_ready=0. Expect out_valid=4'b0000 during reset. One cycle later expect out_valid=4'b0100, out_data[2]=0xDEADBEEF, and out_valid held until out_ready[2]=1.
- Back-pressure isolation: port 1 is full with out_ready[1]=0. A send to port 1 must give in_ready=0. A send to port 3 in the same period must give in_ready=1 and then out_valid[3]=1, while port 1 is unchanged.
- Streaming through a draining port: port 0 is full and out_ready[0]=1 continuously. Send 0x1, 0x2, 0x3 back-to-back to port 0. Expect in_ready=1 every cycle and out_data[0] to show 0x1, 0x2, 0x3 on consecutive cycles with no bubble.
- Out-of-range drop: N_OUTS=3, in_sel=3, in_valid=1 for 5 cycles. Expect in_ready=1 and no out_valid change. With DEMUX_REG_STATS_EN, expect drop_cnt=5. A preloaded drop_cnt of 0xFFFF must stay at 0xFFFF.
- Reset mid-operation: all 4 ports full, assert rst for 1 cycle. The next cycle expect out_valid=0 and out_data=0 on every port.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants for the demux_reg block.
package demux_pkg;

    localparam int unsigned DROP_CNT_WIDTH = 16;
    localparam logic [DROP_CNT_WIDTH-1:0] DROP_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/demux_reg_if.sv
// Handshake bundle for demux_reg: one producer side, N_OUTS consumer sides.
interface demux_reg_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned N_OUTS = 4
);
    localparam int unsigned SEL_WIDTH = $clog2(N_OUTS);

    logic                             in_valid;
    logic                             in_ready;
    logic [SEL_WIDTH-1:0]             in_sel;
    logic [WIDTH-1:0]                 in_data;
    logic [N_OUTS-1:0]                out_valid;
    logic [N_OUTS-1:0]                out_ready;
    logic [N_OUTS-1:0][WIDTH-1:0]     out_data;

    // Driven by the producer/consumers around the demux.
    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Used by the demux itself.
    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/sel_decode.sv
// Binary-to-one-hot select decoder; indices >= N_OUTS decode to all zeros.
module sel_decode #(
    parameter int unsigned N_OUTS    = 4,
    parameter int unsigned SEL_WIDTH = $clog2(N_OUTS)
) (
    input  logic [SEL_WIDTH-1:0] sel,
    output logic [N_OUTS-1:0]    en
);

    // One-hot decode of sel.
    always_comb begin
        en = '0;
        for (int unsigned i = 0; i < N_OUTS; i++) begin
            if (sel == SEL_WIDTH'(i)) begin
                en[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_reg.sv
// Registered 1-to-N demultiplexer with per-port one-entry slots.
// Optional feature: define DEMUX_REG_STATS_EN to add the saturating drop_cnt
// output counting accepted out-of-range transactions.
module demux_reg
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned N_OUTS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    demux_reg_if.slave                bus
`ifdef DEMUX_REG_STATS_EN
    ,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt
`endif
);

    localparam int unsigned SEL_WIDTH = $clog2(N_OUTS);

    logic [N_OUTS-1:0] en;
    logic              accept;

    sel_decode #(
        .N_OUTS    (N_OUTS),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_sel_decode (
        .sel (bus.in_sel),
        .en  (en)
    );

    // Out-of-range selects are always accepted (and discarded); otherwise the
    // target slot must be empty or draining this cycle.
    assign bus.in_ready = (en == '0) ? 1'b1 : |(en & (~bus.out_valid | bus.out_ready));
    assign accept       = bus.in_valid & bus.in_ready;

    for (genvar i = 0; i < N_OUTS; i++) begin : g_slot
        logic             full_q;
        logic [WIDTH-1:0] data_q;
        logic             load;
        logic             drain;

        assign load  = accept & en[i];
        assign drain = full_q & bus.out_ready[i];

        // Slot state: a load wins over a same-cycle drain, keeping the slot full.
        always_ff @(posedge clk) begin
            if (rst) begin
                full_q <= 1'b0;
                data_q <= '0;
            end else begin
                full_q <= load | (full_q & ~drain);
                if (load) begin
                    data_q <= bus.in_data;
                end
            end
        end

        assign bus.out_valid[i] = full_q;
        assign bus.out_data[i]  = data_q;
    end

`ifdef DEMUX_REG_STATS_EN
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q;

    // Saturating count of accepted transactions whose select hit no port.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (accept && (en == '0) && (drop_cnt_q != DROP_CNT_MAX)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_demux_reg.sv
// Directed self-checking bench for demux_reg (4-port and 3-port instances).
module tb_demux_reg;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    demux_reg_if #(.WIDTH(32), .N_OUTS(4)) bus4 ();
    demux_reg_if #(.WIDTH(32), .N_OUTS(3)) bus3 ();

`ifdef DEMUX_REG_STATS_EN
    logic [15:0] drop_cnt4;
    logic [15:0] drop_cnt3;
`endif

    demux_reg #(.WIDTH(32), .N_OUTS(4)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus4)
`ifdef DEMUX_REG_STATS_EN
        ,
        .drop_cnt (drop_cnt4)
`endif
    );

    demux_reg #(.WIDTH(32), .N_OUTS(3)) dut3 (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus3)
`ifdef DEMUX_REG_STATS_EN
        ,
        .drop_cnt (drop_cnt3)
`endif
    );

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus4.in_valid  = 1'b1;
        bus4.in_sel    = 2'd2;
        bus4.in_data   = 32'hDEAD_BEEF;
        bus4.out_ready = 4'b0000;
        tick();
        tick();
        n_cmp++;
        if (bus4.out_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_valid: got %b want 0000", bus4.out_valid);
        end
        n_cmp++;
        if (bus4.out_data[2] !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 00000000", bus4.out_data[2]);
        end
        n_cmp++;
        if (bus4.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", bus4.in_ready);
        end
        n_cmp++;
        if (bus3.out_valid !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_valid3: got %b want 000", bus3.out_valid);
        end
        rst = 1'b0;
        tick();
        bus4.in_valid = 1'b0;
        n_cmp++;
        if (bus4.out_valid !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_valid: got %b want 0100", bus4.out_valid);
        end
        n_cmp++;
        if (bus4.out_data[2] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL single_data: got %h want deadbeef", bus4.out_data[2]);
        end
        tick();
        n_cmp++;
        if (bus4.out_valid !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_hold: got %b want 0100", bus4.out_valid);
        end
        bus4.out_ready = 4'b0100;
        tick();
        bus4.out_ready = 4'b0000;
        n_cmp++;
        if (bus4.out_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_drain: got %b want 0000", bus4.out_valid);
        end
    endtask

    task automatic test_backpressure();
        bus4.in_valid = 1'b1;
        bus4.in_sel   = 2'd1;
        bus4.in_data  = 32'h1111_1111;
        tick();
        bus4.in_data = 32'h2222_2222;
        #1;
        n_cmp++;
        if (bus4.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_blocked_ready: got %b want 0", bus4.in_ready);
        end
        tick();
        n_cmp++;
        if (bus4.out_data[1] !== 32'h1111_1111) begin
            n_fail++;
            $display("FAIL bp_port1_kept: got %h want 11111111", bus4.out_data[1]);
        end
        bus4.in_sel  = 2'd3;
        bus4.in_data = 32'h3333_3333;
        #1;
        n_cmp++;
        if (bus4.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_other_ready: got %b want 1", bus4.in_ready);
        end
        tick();
        bus4.in_valid = 1'b0;
        n_cmp++;
        if (bus4.out_valid !== 4'b1010) begin
            n_fail++;
            $display("FAIL bp_valid: got %b want 1010", bus4.out_valid);
        end
        n_cmp++;
        if (bus4.out_data[3] !== 32'h3333_3333 || bus4.out_data[1] !== 32'h1111_1111) begin
            n_fail++;
            $display("FAIL bp_data: got p3=%h p1=%h want p3=33333333 p1=11111111",
                     bus4.out_data[3], bus4.out_data[1]);
        end
        bus4.out_ready = 4'b1111;
        tick();
        bus4.out_ready = 4'b0000;
        n_cmp++;
        if (bus4.out_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL bp_cleanup: got %b want 0000", bus4.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3];
        vals[0] = 32'h1;
        vals[1] = 32'h2;
        vals[2] = 32'h3;
        bus4.in_valid = 1'b1;
        bus4.in_sel   = 2'd0;
        bus4.in_data  = 32'hA0;
        tick();
        bus4.out_ready = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            bus4.in_data = vals[k];
            #1;
            n_cmp++;
            if (bus4.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_ready[%0d]: got %b want 1", k, bus4.in_ready);
            end
            tick();
            n_cmp++;
            if (bus4.out_valid[0] !== 1'b1 || bus4.out_data[0] !== vals[k]) begin
                n_fail++;
                $display("FAIL stream_data[%0d]: got v=%b d=%h want v=1 d=%h",
                         k, bus4.out_valid[0], bus4.out_data[0], vals[k]);
            end
        end
        bus4.in_valid = 1'b0;
        tick();
        bus4.out_ready = 4'b0000;
        n_cmp++;
        if (bus4.out_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL stream_empty: got %b want 0000", bus4.out_valid);
        end
    endtask

    task automatic test_drop();
        bus3.out_ready = 3'b000;
        bus3.in_valid  = 1'b1;
        bus3.in_sel    = 2'd1;
        bus3.in_data   = 32'h5555_AAAA;
        tick();
        bus3.in_sel  = 2'd3;
        bus3.in_data = 32'h7777_7777;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp++;
            if (bus3.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL drop_ready[%0d]: got %b want 1", k, bus3.in_ready);
            end
            tick();
            n_cmp++;
            if (bus3.out_valid !== 3'b010 || bus3.out_data[1] !== 32'h5555_AAAA) begin
                n_fail++;
                $display("FAIL drop_no_change[%0d]: got v=%b d1=%h want v=010 d1=5555aaaa",
                         k, bus3.out_valid, bus3.out_data[1]);
            end
        end
`ifdef DEMUX_REG_STATS_EN
        n_cmp++;
        if (drop_cnt3 !== 16'd5) begin
            n_fail++;
            $display("FAIL drop_cnt: got %0d want 5", drop_cnt3);
        end
        repeat (65540) @(posedge clk);
        #1;
        n_cmp++;
        if (drop_cnt3 !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL drop_cnt_sat: got %h want ffff", drop_cnt3);
        end
`endif
        bus3.in_valid  = 1'b0;
        bus3.out_ready = 3'b111;
        tick();
        bus3.out_ready = 3'b000;
    endtask

    task automatic test_reset_mid();
        bus4.out_ready = 4'b0000;
        bus4.in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus4.in_sel  = 2'(k);
            bus4.in_data = 32'h1000 + 32'(k);
            tick();
        end
        bus4.in_valid = 1'b0;
        n_cmp++;
        if (bus4.out_valid !== 4'b1111) begin
            n_fail++;
            $display("FAIL mid_fill: got %b want 1111", bus4.out_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (bus4.out_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_valid: got %b want 0000", bus4.out_valid);
        end
        n_cmp++;
        if (bus4.out_data !== '0) begin
            n_fail++;
            $display("FAIL mid_data: got %h want 0", bus4.out_data);
        end
        tick();
        n_cmp++;
        if (bus4.out_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_after: got %b want 0000", bus4.out_valid);
        end
    endtask

    initial begin
        bus4.in_valid  = 1'b0;
        bus4.in_sel    = '0;
        bus4.in_data   = '0;
        bus4.out_ready = '0;
        bus3.in_valid  = 1'b0;
        bus3.in_sel    = '0;
        bus3.in_data   = '0;
        bus3.out_ready = '0;
        test_reset();
        test_backpressure();
        test_back_to_back();
        test_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
